nios_nios2_qsys_0_mul_seq: RTL and testbench

- Multiply sequencer sitting directly upstream of the Nios II M-stage multiplier cell.
- Accepts 32x32 multiply requests over a valid/ready handshake and drives the cell's two 32-bit source buses.
- Captures the cell's 32-bit low-product output one cycle after each issue.
- MUL: one pass. MULXUU/MULXSU/MULXSS: the 32x32 product is split into four 16x16 partial products fed through the cell, accumulated to 64 bits, sign-corrected, and the high word returned.

---
 rtl/nios_nios2_qsys_0_mul_seq_if.sv | 29 ++
 rtl/nios_nios2_qsys_0_mul_seq.sv | 193 +++++++++++++++++++
 tb/tb_nios_nios2_qsys_0_mul_seq.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/nios_nios2_qsys_0_mul_seq_if.sv
// Request/response and multiplier-cell bus bundle for the Nios II multiply sequencer.
// The slave modport is the sequencer; the master modport is the requester plus the cell.
interface nios_nios2_qsys_0_mul_seq_if #(
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [DATA_W-1:0] req_a;
   logic [DATA_W-1:0] req_b;
   logic              kill;
   logic [DATA_W-1:0] M_mul_src1;
   logic [DATA_W-1:0] M_mul_src2;
   logic [DATA_W-1:0] M_mul_cell_result;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_result;
   logic              resp_illegal;

   modport slave (
      input  req_valid, req_op, req_a, req_b, kill, M_mul_cell_result, resp_ready,
      output req_ready, M_mul_src1, M_mul_src2, resp_valid, resp_result, resp_illegal
   );

   modport master (
      output req_valid, req_op, req_a, req_b, kill, M_mul_cell_result, resp_ready,
      input  req_ready, M_mul_src1, M_mul_src2, resp_valid, resp_result, resp_illegal
   );
endinterface

// File: rtl/nios_nios2_qsys_0_mul_seq.sv
// Multiply sequencer feeding the Nios II M-stage multiplier cell: MUL in one pass,
// MULX* as four 16x16 passes. Macro NIOS_MUL_SEQ_MULX_EN builds the MULX* datapath.
module nios_nios2_qsys_0_mul_seq #(
   parameter int DATA_W   = 32,
   parameter int CELL_LAT = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   nios_nios2_qsys_0_mul_seq_if.slave  bus
);

   localparam int HALF_W = DATA_W / 2;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RESP} state_t;
   typedef enum logic [1:0] {OP_MUL, OP_MULXUU, OP_MULXSU, OP_MULXSS} op_t;

   state_t            state, state_nxt;
   logic [1:0]        pass, pass_nxt;
   op_t               op_q;
   logic [DATA_W-1:0] a_q, b_q;
   logic              accept;
   logic              abort;
   logic              mulx_path;
   logic              issue_last;
   logic              issuing;
   logic [CELL_LAT-1:0] cap_pipe;
   logic              cap_valid;

   assign accept     = bus.req_valid & bus.req_ready & ~bus.kill;
   assign abort      = bus.kill & (state != S_IDLE);
   assign issuing    = (state == S_ISSUE);
   assign cap_valid  = cap_pipe[CELL_LAT-1];

`ifdef NIOS_MUL_SEQ_MULX_EN
   assign mulx_path  = (op_q != OP_MUL);
`else
   assign mulx_path  = 1'b0;
`endif
   assign issue_last = ~mulx_path | (pass == 2'd3);

   assign bus.req_ready  = (state == S_IDLE) & ~reset;
   assign bus.resp_valid = (state == S_RESP);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         pass  <= 2'd0;
      end else begin
         // NOTE: every clocked assignment is non-blocking so all registers sample
         // pre-edge values regardless of statement order.
         state <= state_nxt;
         pass  <= pass_nxt;
      end
   end

   always_comb begin
      // NOTE: defaults first, so no path through the case leaves a variable
      // unassigned and infers a latch.
      state_nxt = state;
      pass_nxt  = pass;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = S_ISSUE;
               pass_nxt  = 2'd0;
            end
         end
         S_ISSUE: begin
            if (bus.kill) begin
               state_nxt = S_IDLE;
               pass_nxt  = 2'd0;
            end else if (issue_last) begin
               state_nxt = S_DRAIN;
               pass_nxt  = 2'd0;
            end else begin
               pass_nxt  = pass + 2'd1;
            end
         end
         S_DRAIN: state_nxt = bus.kill ? S_IDLE : S_RESP;
         S_RESP:  if (bus.kill || bus.resp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Cell source buses: full operands for MUL, zero-extended halves per MULX pass.
   always_comb begin
      bus.M_mul_src1 = '0;
      bus.M_mul_src2 = '0;
      if (state == S_ISSUE) begin
         if (!mulx_path) begin
            bus.M_mul_src1 = a_q;
            bus.M_mul_src2 = b_q;
         end else begin
            case (pass)
               2'd0: begin
                  bus.M_mul_src1 = {{HALF_W{1'b0}}, a_q[HALF_W-1:0]};
                  bus.M_mul_src2 = {{HALF_W{1'b0}}, b_q[HALF_W-1:0]};
               end
               2'd1: begin
                  bus.M_mul_src1 = {{HALF_W{1'b0}}, a_q[DATA_W-1:HALF_W]};
                  bus.M_mul_src2 = {{HALF_W{1'b0}}, b_q[HALF_W-1:0]};
               end
               2'd2: begin
                  bus.M_mul_src1 = {{HALF_W{1'b0}}, a_q[HALF_W-1:0]};
                  bus.M_mul_src2 = {{HALF_W{1'b0}}, b_q[DATA_W-1:HALF_W]};
               end
               default: begin
                  bus.M_mul_src1 = {{HALF_W{1'b0}}, a_q[DATA_W-1:HALF_W]};
                  bus.M_mul_src2 = {{HALF_W{1'b0}}, b_q[DATA_W-1:HALF_W]};
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q <= OP_MUL;
         a_q  <= '0;
         b_q  <= '0;
      end else if (accept) begin
         op_q <= op_t'(bus.req_op);
         a_q  <= bus.req_a;
         b_q  <= bus.req_b;
      end
   end

`ifdef NIOS_MUL_SEQ_MULX_EN
   logic [1:0]          pass_pipe [CELL_LAT];
   logic [1:0]          pass_d;
   logic [2*DATA_W-1:0] acc, acc_term, acc_sum;
   logic [DATA_W-1:0]   corr_a, corr_b, mulx_hi;

   assign pass_d = pass_pipe[CELL_LAT-1];

   // Partial products land at bit 0, HALF_W, HALF_W, DATA_W; the signed fix-up
   // only touches the high word, so it is done mod 2^DATA_W there.
   always_comb begin
      acc_term = {{DATA_W{1'b0}}, bus.M_mul_cell_result};
      case (pass_d)
         2'd0:    acc_term = acc_term;
         2'd3:    acc_term = acc_term << DATA_W;
         default: acc_term = acc_term << HALF_W;
      endcase
      acc_sum = acc + acc_term;
      corr_a  = ((op_q == OP_MULXSU || op_q == OP_MULXSS) && a_q[DATA_W-1]) ? b_q : '0;
      corr_b  = ((op_q == OP_MULXSS) && b_q[DATA_W-1]) ? a_q : '0;
      mulx_hi = acc_sum[2*DATA_W-1:DATA_W] - corr_a - corr_b;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cap_pipe         <= '0;
         bus.resp_result  <= '0;
         bus.resp_illegal <= 1'b0;
`ifdef NIOS_MUL_SEQ_MULX_EN
         acc              <= '0;
         for (int i = 0; i < CELL_LAT; i++) pass_pipe[i] <= 2'd0;
`endif
      end else if (abort) begin
         cap_pipe <= '0;
`ifdef NIOS_MUL_SEQ_MULX_EN
         acc      <= '0;
`endif
      end else begin
         for (int i = CELL_LAT - 1; i > 0; i--) cap_pipe[i] <= cap_pipe[i-1];
         cap_pipe[0] <= issuing;
`ifdef NIOS_MUL_SEQ_MULX_EN
         for (int i = CELL_LAT - 1; i > 0; i--) pass_pipe[i] <= pass_pipe[i-1];
         pass_pipe[0] <= pass;
         if (cap_valid) begin
            if (!mulx_path) begin
               bus.resp_result  <= bus.M_mul_cell_result;
               bus.resp_illegal <= 1'b0;
            end else if (pass_d == 2'd3) begin
               bus.resp_result  <= mulx_hi;
               bus.resp_illegal <= 1'b0;
               acc              <= '0;
            end else begin
               acc <= acc_sum;
            end
         end
`else
         if (cap_valid) begin
            bus.resp_result  <= (op_q == OP_MUL) ? bus.M_mul_cell_result : '0;
            bus.resp_illegal <= (op_q != OP_MUL);
         end
`endif
      end
   end

endmodule

// File: tb/tb_nios_nios2_qsys_0_mul_seq.sv
// Directed self-checking bench for nios_nios2_qsys_0_mul_seq with a registered
// behavioural multiplier cell; expectations follow NIOS_MUL_SEQ_MULX_EN.
module tb_nios_nios2_qsys_0_mul_seq;

`ifdef NIOS_MUL_SEQ_MULX_EN
   localparam bit XEN  = 1'b1;
   localparam int XLAT = 6;
   localparam int KILL_AT = 3;
`else
   localparam bit XEN  = 1'b0;
   localparam int XLAT = 3;
   localparam int KILL_AT = 2;
`endif

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   nios_nios2_qsys_0_mul_seq_if bus ();

   nios_nios2_qsys_0_mul_seq dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) bus.M_mul_cell_result <= bus.M_mul_src1 * bus.M_mul_src2;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Entered just after a negedge; returns just after the negedge of cycle T+1.
   task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_valid = 1'b1;
      check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_a     = 32'hDEAD_BEEF;
      bus.req_b     = 32'h1234_5678;
   endtask

   // Waits for resp_valid starting at cycle offset 'start', checks it, lets it retire.
   task automatic wait_resp(input int start, input int exp_lat, input logic [31:0] exp_res,
                            input logic exp_ill, input string tag);
      int lat;
      lat = start;
      while (!bus.resp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " result"}, bus.resp_result, exp_res);
      check({tag, " illegal"}, 32'(bus.resp_illegal), 32'(exp_ill));
      @(negedge clk);
      check({tag, " retire valid"}, 32'(bus.resp_valid), 32'd0);
      check({tag, " retire ready"}, 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      int lat;
      bit seen;

      reset          = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_op     = 2'd0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.kill       = 1'b0;
      bus.resp_ready = 1'b1;
      repeat (2) @(negedge clk);

      check("rst req_ready", 32'(bus.req_ready), 32'd0);
      check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst resp_result", bus.resp_result, 32'd0);
      check("rst resp_illegal", 32'(bus.resp_illegal), 32'd0);
      check("rst src1", bus.M_mul_src1, 32'd0);
      check("rst src2", bus.M_mul_src2, 32'd0);
      reset = 1'b0;
      #1;
      check("post-rst req_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);

      // MUL basic, with source bus and drain checks
      do_req(2'd0, 32'h0001_0003, 32'h0002_0005, "mul");
      check("mul src1", bus.M_mul_src1, 32'h0001_0003);
      check("mul src2", bus.M_mul_src2, 32'h0002_0005);
      check("mul issue ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      check("mul drain src1", bus.M_mul_src1, 32'd0);
      wait_resp(2, 3, 32'h000B_000F, 1'b0, "mul");

      // MULXUU with pass-by-pass source buses
      do_req(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulxuu");
`ifdef NIOS_MUL_SEQ_MULX_EN
      for (int i = 0; i < 4; i++) begin
         check("mulxuu src1", bus.M_mul_src1, 32'h0000_FFFF);
         check("mulxuu src2", bus.M_mul_src2, 32'h0000_FFFF);
         @(negedge clk);
      end
      check("mulxuu drain src1", bus.M_mul_src1, 32'd0);
      wait_resp(5, XLAT, 32'hFFFF_FFFE, 1'b0, "mulxuu");
`else
      check("mulxuu src1", bus.M_mul_src1, 32'hFFFF_FFFF);
      wait_resp(1, XLAT, 32'h0, 1'b1, "mulxuu");
`endif

      do_req(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulxss m1");
      wait_resp(1, XLAT, 32'h0, !XEN, "mulxss m1");
      do_req(2'd3, 32'h8000_0000, 32'h8000_0000, "mulxss min");
      wait_resp(1, XLAT, XEN ? 32'h4000_0000 : 32'h0, !XEN, "mulxss min");
      do_req(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulxsu");
      wait_resp(1, XLAT, XEN ? 32'hFFFF_FFFF : 32'h0, !XEN, "mulxsu");

      // MUL after an illegal/MULX op must report legal again
      do_req(2'd0, 32'h0000_0100, 32'h0000_0100, "mul2");
      wait_resp(1, 3, 32'h0001_0000, 1'b0, "mul2");

      // Backpressure: response held, new request ignored
      bus.resp_ready = 1'b0;
      do_req(2'd0, 32'd7, 32'd6, "bp");
      lat = 1;
      while (!bus.resp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("bp latency", 32'(lat), 32'd3);
      check("bp result", bus.resp_result, 32'd42);
      bus.req_valid = 1'b1;
      bus.req_op    = 2'd0;
      bus.req_a     = 32'd2;
      bus.req_b     = 32'd2;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp hold valid", 32'(bus.resp_valid), 32'd1);
         check("bp hold result", bus.resp_result, 32'd42);
         check("bp hold ready", 32'(bus.req_ready), 32'd0);
      end
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      @(negedge clk);
      check("bp release valid", 32'(bus.resp_valid), 32'd0);
      check("bp release ready", 32'(bus.req_ready), 32'd1);
      check("bp ignored src1", bus.M_mul_src1, 32'd0);

      // kill coincident with a request in IDLE drops it
      bus.req_valid = 1'b1;
      bus.req_a     = 32'd9;
      bus.req_b     = 32'd9;
      bus.kill      = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.kill      = 1'b0;
      check("idle kill ready", 32'(bus.req_ready), 32'd1);
      check("idle kill src1", bus.M_mul_src1, 32'd0);

      // kill mid-operation (pass 2 of MULXSS when built)
      do_req(2'd3, 32'h8000_0000, 32'h8000_0000, "kill");
      for (int i = 1; i < KILL_AT; i++) @(negedge clk);
      bus.kill = 1'b1;
      @(negedge clk);
      bus.kill = 1'b0;
      check("kill ready", 32'(bus.req_ready), 32'd1);
      check("kill src1", bus.M_mul_src1, 32'd0);
      seen = 1'b0;
      repeat (10) begin
         if (bus.resp_valid) seen = 1'b1;
         @(negedge clk);
      end
      check("kill no resp", 32'(seen), 32'd0);
      do_req(2'd0, 32'd3, 32'd5, "post-kill mul");
      wait_resp(1, 3, 32'h0000_000F, 1'b0, "post-kill mul");

      // Asynchronous reset mid-operation
      do_req(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "midrst");
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst req_ready", 32'(bus.req_ready), 32'd0);
      check("midrst resp_valid", 32'(bus.resp_valid), 32'd0);
      check("midrst resp_result", bus.resp_result, 32'd0);
      check("midrst src1", bus.M_mul_src1, 32'd0);
      check("midrst src2", bus.M_mul_src2, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst release ready", 32'(bus.req_ready), 32'd1);
      do_req(2'd0, 32'h1234_5678, 32'h0000_0010, "post-rst mul");
      wait_resp(1, 3, 32'h2345_6780, 1'b0, "post-rst mul");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
